serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one result bit per clock, LSB first.
// Result and final borrow are published only when the last bit is done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit;
    logic             br_nxt;

    // Full-subtractor cell on the current operand LSBs
    always_comb begin
        d_bit  = a_q[0] ^ b_q[0] ^ br_q;
        br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_nxt;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8.
// Inputs change at/after the falling edge; outputs are sampled there too.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           n_chk;
    int           n_err;
    int           cyc;
    int           busy_run;
    int           last_done;
    int           prev_done;
    logic [W-1:0] hold_d;
    logic         hold_b;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .diff (diff),
        .bout (bout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used for latency and spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Wait for idle, present one operation, drop start after acceptance
    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input bit push);
        int   guard;
        exp_t e;
        logic [W:0] r;
        guard = 0;
        while ((busy || done) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("idle_timeout", 1, 0);
        start = 1'b1;
        a     = va;
        b     = vb;
        r     = {1'b0, va} - {1'b0, vb};
        e.d   = r[W-1:0];
        e.bo  = r[W];
        e.acc = cyc + 1;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Output monitor: result compare, pulse rules, hold rules
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_d   = '0;
            hold_b   = 1'b0;
            busy_run = 0;
        end else begin
            chk("busy_done_excl", busy && done, 0);
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("diff", diff, e.d);
                    chk("bout", bout, e.bo);
                    chk("latency", cyc - e.acc + 1, W + 1);
                    chk("busy_cycles", busy_run, W);
                end
                busy_run  = 0;
                prev_done = last_done;
                last_done = cyc;
                hold_d    = diff;
                hold_b    = bout;
            end else begin
                chk("diff_hold", diff, hold_d);
                chk("bout_hold", bout, hold_b);
            end
        end
    end

    initial begin
        cyc       = 0;
        n_chk     = 0;
        n_err     = 0;
        busy_run  = 0;
        last_done = 0;
        prev_done = 0;
        hold_d    = '0;
        hold_b    = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        issue(8'h05, 8'h03, 1);
        issue(8'h03, 8'h05, 1);
        issue(8'h00, 8'h00, 1);
        issue(8'h00, 8'h01, 1);
        issue(8'hFF, 8'h00, 1);
        issue(8'h00, 8'hFF, 1);
        issue(8'hFF, 8'hFF, 1);
        drain();

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                issue(W'(ia * 17), W'(ib * 16 + ia), 1);
            end
        end
        for (int k = 0; k < 200; k++) begin
            issue(W'($urandom), W'($urandom), 1);
        end
        drain();

        // start held high and operands changed while running
        issue(8'h3C, 8'h0F, 1);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        repeat (5) @(negedge clk);
        start = 1'b0;
        drain();

        // reset in the middle of an operation
        issue(8'h12, 8'h34, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(8'h80, 8'h01, 1);
        drain();

        // back-to-back operations
        issue(8'h40, 8'h10, 1);
        issue(8'h10, 8'h40, 1);
        drain();
        chk("b2b_spacing", last_done - prev_done, W + 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
